// File: rtl/gerador_substantivo.sv
// Word generator: plays a type note then the end note on Tom/Nota/Ready, with a 1-deep request buffer.
// Latency 1 cycle from Start to first Ready; no backpressure, excess requests are dropped with Overrun.
module gerador_substantivo #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [1:0] Tipo_in,
  output logic       Tom,
  output logic [2:0] Nota,
  output logic       Ready,
  output logic       Busy,
  output logic       Done,
  output logic       Err,
  output logic       Overrun
);

  typedef enum logic [2:0] {IDLE, TYPE, GAP1, ENDN, GAP2} state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

  state_t     state, nxt_state;
  logic [7:0] cnt, nxt_cnt;
  logic [1:0] cur_type, nxt_type;
  logic       buf_full, nxt_buf_full;
  logic [1:0] buf_type, nxt_buf_type;
  logic       nxt_err, nxt_ovr;
  logic       start_ok, last, exit_now;

  function automatic logic [2:0] note_of(input logic [1:0] t);
    case (t)
      2'b11:   note_of = 3'b011;
      2'b10:   note_of = 3'b100;
      2'b01:   note_of = 3'b101;
      default: note_of = 3'b000;
    endcase
  endfunction

  assign start_ok = Start && (Tipo_in != 2'b00);
  assign last     = (cnt == 8'd0);

  always_comb begin
    nxt_state    = state;
    nxt_cnt      = cnt - 8'd1;
    nxt_type     = cur_type;
    nxt_buf_full = buf_full;
    nxt_buf_type = buf_type;
    nxt_err      = Start && (Tipo_in == 2'b00);
    nxt_ovr      = 1'b0;
    exit_now     = 1'b0;

    case (state)
      IDLE: begin
        nxt_cnt = cnt;
        if (start_ok) begin
          nxt_state = TYPE;
          nxt_type  = Tipo_in;
          nxt_cnt   = HOLD_LOAD;
        end
      end
      TYPE: begin
        if (last) begin
          if (GAP_CYCLES > 0) begin
            nxt_state = GAP1;
            nxt_cnt   = GAP_LOAD;
          end else begin
            nxt_state = ENDN;
            nxt_cnt   = HOLD_LOAD;
          end
        end
      end
      GAP1: begin
        if (last) begin
          nxt_state = ENDN;
          nxt_cnt   = HOLD_LOAD;
        end
      end
      ENDN: begin
        if (last) begin
          if (GAP_CYCLES > 0) begin
            nxt_state = GAP2;
            nxt_cnt   = GAP_LOAD;
          end else begin
            exit_now = 1'b1;
          end
        end
      end
      GAP2: begin
        if (last) exit_now = 1'b1;
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = 8'd0;
      end
    endcase

    // A buffered word drains with no IDLE cycle; a Start in the same cycle refills the freed slot.
    if (exit_now) begin
      if (buf_full) begin
        nxt_state    = TYPE;
        nxt_type     = buf_type;
        nxt_cnt      = HOLD_LOAD;
        nxt_buf_full = start_ok;
        if (start_ok) nxt_buf_type = Tipo_in;
      end else if (start_ok) begin
        nxt_state = TYPE;
        nxt_type  = Tipo_in;
        nxt_cnt   = HOLD_LOAD;
      end else begin
        nxt_state = IDLE;
        nxt_cnt   = 8'd0;
      end
    end else if (start_ok && (state != IDLE)) begin
      if (!buf_full) begin
        nxt_buf_full = 1'b1;
        nxt_buf_type = Tipo_in;
      end else begin
        nxt_ovr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      cur_type <= 2'b00;
      buf_full <= 1'b0;
      buf_type <= 2'b00;
      Tom      <= 1'b0;
      Nota     <= 3'b000;
      Ready    <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Err      <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      cur_type <= nxt_type;
      buf_full <= nxt_buf_full;
      buf_type <= nxt_buf_type;
      Tom      <= 1'b0;
      Nota     <= (nxt_state == TYPE) ? note_of(nxt_type) : 3'b000;
      Ready    <= (nxt_state == TYPE) || (nxt_state == ENDN);
      Busy     <= (nxt_state != IDLE);
      Done     <= (nxt_state == ENDN) && (nxt_cnt == 8'd0);
      Err      <= nxt_err;
      Overrun  <= nxt_ovr;
    end
  end

endmodule

// File: tb/tb_gerador_substantivo.sv
// Bench for gerador_substantivo: cycle-exact timeline checks plus a note scoreboard fed at stimulus time.
module tb_gerador_substantivo;

  logic       clk;
  logic       Reset;
  logic       Start;
  logic [1:0] Tipo_in;
  logic       Tom;
  logic [2:0] Nota;
  logic       Ready;
  logic       Busy;
  logic       Done;
  logic       Err;
  logic       Overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [2:0] exp_q[$];

  logic       mon_en  = 1'b0;
  int         run_len = 0;
  logic [2:0] run_nota = 3'b000;

  gerador_substantivo #(.HOLD_CYCLES(4), .GAP_CYCLES(2)) dut (
    .clk     (clk),
    .Reset   (Reset),
    .Start   (Start),
    .Tipo_in (Tipo_in),
    .Tom     (Tom),
    .Nota    (Nota),
    .Ready   (Ready),
    .Busy    (Busy),
    .Done    (Done),
    .Err     (Err),
    .Overrun (Overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] note_of(input logic [1:0] t);
    case (t)
      2'b11:   note_of = 3'b011;
      2'b10:   note_of = 3'b100;
      2'b01:   note_of = 3'b101;
      default: note_of = 3'b000;
    endcase
  endfunction

  // Expected {Tom,Nota,Ready,Busy,Done,Err,Overrun} at cycle r of a word accepted at cycle 0.
  function automatic logic [8:0] word_out(input int r, input logic [1:0] t);
    logic [8:0] v;
    v = '0;
    if (r >= 1 && r <= 4)
      v = {1'b0, note_of(t), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    else if (r == 5 || r == 6 || r == 11 || r == 12)
      v = {1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    else if (r >= 7 && r <= 10)
      v = {1'b0, 3'b000, 1'b1, 1'b1, (r == 10), 1'b0, 1'b0};
    return v;
  endfunction

  function automatic logic [8:0] outs();
    return {Tom, Nota, Ready, Busy, Done, Err, Overrun};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Each completed Ready run is one note: compare against the scoreboard head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (Reset) begin
        run_len = 0;
      end else if (Ready) begin
        if (run_len == 0) run_nota = Nota;
        run_len++;
      end else if (run_len > 0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL note_unexpected: got nota=%b len=%0d, required no note", run_nota, run_len);
        end else begin
          logic [2:0] e;
          e = exp_q.pop_front();
          if (run_nota !== e || run_len != 4) begin
            bad++;
            $display("FAIL note_seq: got nota=%b len=%0d, required nota=%b len=4", run_nota, run_len, e);
          end
        end
        run_len = 0;
      end
    end
  end

  task automatic test_reset();
    Reset = 1'b1;
    Start = 1'b1;
    Tipo_in = 2'b11;
    tick();
    tick();
    total++;
    if (outs() !== 9'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b, required %b", outs(), 9'd0);
    end
    Start = 1'b0;
    Reset = 1'b0;
    tick();
    total++;
    if (outs() !== 9'd0) begin
      bad++;
      $display("FAIL reset_release: got %b, required %b", outs(), 9'd0);
    end
  endtask

  task automatic test_single_word(input logic [1:0] t);
    tick();
    cyc = 0;
    Start = 1'b1;
    Tipo_in = t;
    exp_q.push_back(note_of(t));
    exp_q.push_back(3'b000);
    for (int i = 1; i <= 14; i++) begin
      tick();
      Start = 1'b0;
      Tipo_in = 2'($urandom_range(0, 3));
      total++;
      if (outs() !== word_out(cyc, t)) begin
        bad++;
        $display("FAIL single_word_%b cycle %0d: got %b, required %b", t, cyc, outs(), word_out(cyc, t));
      end
    end
  endtask

  task automatic test_invalid();
    logic [8:0] e;
    tick();
    cyc = 0;
    Start = 1'b1;
    Tipo_in = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      tick();
      Start = 1'b0;
      e = (cyc == 1) ? 9'b0_000_00010 : 9'd0;
      total++;
      if (outs() !== e) begin
        bad++;
        $display("FAIL invalid_err cycle %0d: got %b, required %b", cyc, outs(), e);
      end
    end
  endtask

  task automatic test_queue_overrun();
    logic [8:0] e;
    tick();
    cyc = 0;
    Start = 1'b1;
    Tipo_in = 2'b11;
    exp_q.push_back(3'b011);
    exp_q.push_back(3'b000);
    for (int i = 1; i <= 26; i++) begin
      tick();
      e = word_out(cyc, 2'b11) | word_out(cyc - 12, 2'b01);
      if (cyc == 6) e[0] = 1'b1;
      total++;
      if (outs() !== e) begin
        bad++;
        $display("FAIL queue_overrun cycle %0d: got %b, required %b", cyc, outs(), e);
      end
      Start = (cyc == 3) || (cyc == 5);
      Tipo_in = (cyc == 3) ? 2'b01 : 2'b10;
      if (cyc == 3) begin
        exp_q.push_back(3'b101);
        exp_q.push_back(3'b000);
      end
    end
    Start = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [8:0] e;
    tick();
    cyc = 0;
    Start = 1'b1;
    Tipo_in = 2'b11;
    exp_q.push_back(3'b011);
    exp_q.push_back(3'b000);
    for (int i = 1; i <= 38; i++) begin
      tick();
      e = word_out(cyc, 2'b11) | word_out(cyc - 12, 2'b01) | word_out(cyc - 24, 2'b10);
      total++;
      if (outs() !== e) begin
        bad++;
        $display("FAIL drain_collision cycle %0d: got %b, required %b", cyc, outs(), e);
      end
      Start = (cyc == 3) || (cyc == 12);
      Tipo_in = (cyc == 3) ? 2'b01 : 2'b10;
      if (cyc == 3 || cyc == 12) begin
        exp_q.push_back(note_of(Tipo_in));
        exp_q.push_back(3'b000);
      end
    end
    Start = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    logic [8:0] e;
    tick();
    cyc = 0;
    Start = 1'b1;
    Tipo_in = 2'b11;
    exp_q.push_back(3'b011);
    exp_q.push_back(3'b000);
    for (int i = 1; i <= 20; i++) begin
      tick();
      Reset = 1'b0;
      e = (cyc <= 8) ? word_out(cyc, 2'b11) : 9'd0;
      total++;
      if (outs() !== e) begin
        bad++;
        $display("FAIL reset_mid_word cycle %0d: got %b, required %b", cyc, outs(), e);
      end
      Start = (cyc == 3);
      Tipo_in = 2'b01;
      if (cyc == 8) begin
        Reset = 1'b1;
        void'(exp_q.pop_back());
      end
    end
    Start = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Tipo_in = 2'b00;
    test_reset();
    mon_en = 1'b1;
    test_single_word(2'b11);
    test_single_word(2'b10);
    test_single_word(2'b01);
    test_invalid();
    test_queue_overrun();
    test_back_to_back();
    test_reset_mid_word();
    tick();
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL notes_missing: got %0d notes still pending, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
